aq_axi_sdma64_slave_mem: RTL and testbench

- AXI4 64-bit slave memory; the responder end for the sdma64 master's write and read bursts.
- Backs a word-addressed register array of 2^ADDR_WIDTH bytes.
- Independent write (AW/W/B) and read (AR/R) engines; used as the DMA target in simulation and on-chip scratch memory.
- No ID or user signals: the master's IDs are constant 0, and the interconnect ties them off.

---
 rtl/aq_axi_sdma64_pkg.sv | 22 ++
 rtl/aq_axi_sdma64_slave_mem_if.sv | 43 ++++
 rtl/aq_axi_sdma64_ram.sv | 26 ++
 rtl/aq_axi_sdma64_slave_mem.sv | 165 ++++++++++++++++
 tb/tb_aq_axi_sdma64_slave_mem.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aq_axi_sdma64_pkg.sv
// Shared constants and FSM encodings for the sdma64 AXI slave memory.
package aq_axi_sdma64_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_ADDR_W = 32;
  localparam int BEAT_BYTES = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/aq_axi_sdma64_slave_mem_if.sv
// AXI4 write/read channel bundle (no ID/user) plus FSM state taps.
// Every channel: a transfer happens on a rising clock edge where valid and ready are both 1.
interface aq_axi_sdma64_slave_mem_if;
  import aq_axi_sdma64_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [BEAT_BYTES-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  w_state_e              w_state;
  r_state_e              r_state;

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid,
           w_state, r_state
  );

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid,
           w_state, r_state
  );
endinterface

// File: rtl/aq_axi_sdma64_ram.sv
// 64-bit word RAM: byte-enabled write port, registered read port, read-before-write.
module aq_axi_sdma64_ram
  import aq_axi_sdma64_pkg::*;
#(
  parameter int IDX_W = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [BEAT_BYTES-1:0] wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [AXI_DATA_W-1:0] rdata
);

  logic [AXI_DATA_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int b = 0; b < BEAT_BYTES; b++) begin
      if (we && wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/aq_axi_sdma64_slave_mem.sv
// AXI4 64-bit slave memory with independent write (AW/W/B) and read (AR/R) engines.
module aq_axi_sdma64_slave_mem
  import aq_axi_sdma64_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input logic ACLK,
  input logic ARESET,
  aq_axi_sdma64_slave_mem_if.slave s_axi
);

  localparam int IDX_W = ADDR_WIDTH - 3;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  w_state_e        w_state;
  logic            aw_ready;
  logic            w_ready;
  logic            b_valid;
  logic [1:0]      b_resp;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]      w_len;
  logic [7:0]      w_cnt;

  r_state_e        r_state;
  logic            ar_ready;
  logic            r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;

  logic            ram_we;
  logic            ram_re;
  logic [IDX_W-1:0] ram_raddr;
  logic [AXI_DATA_W-1:0] ram_q;
  logic            ar_take;
  logic            r_adv;
  logic            w_end_cnt;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[AXI_ADDR_W-1:ADDR_WIDTH], s_axi.awaddr[2:0],
                              s_axi.araddr[AXI_ADDR_W-1:ADDR_WIDTH], s_axi.araddr[2:0]};

  assign w_end_cnt = (w_cnt == w_len);

  // Write engine. Ready is registered, so AWREADY returns one cycle after B completes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      w_idx    <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi.awvalid && aw_ready) begin
            w_idx    <= s_axi.awaddr[ADDR_WIDTH-1:3];
            w_len    <= s_axi.awlen;
            w_cnt    <= '0;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            w_state  <= W_DATA;
          end else begin
            aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (s_axi.wvalid && w_ready) begin
            w_idx <= w_idx + IDX_ONE;
            w_cnt <= w_cnt + 8'd1;
            // Only the terminating beat can have WLAST and the count disagree.
            if (s_axi.wlast || w_end_cnt) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_resp  <= (s_axi.wlast != w_end_cnt) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            b_valid <= 1'b0;
            b_resp  <= RESP_OKAY;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign ram_we = (w_state == W_DATA) && s_axi.wvalid && w_ready;

  assign ar_take   = (r_state == R_IDLE) && s_axi.arvalid && ar_ready;
  assign r_adv     = (r_state == R_DATA) && r_valid && s_axi.rready && (r_cnt != r_len);
  assign ram_re    = ar_take || r_adv;
  assign ram_raddr = ar_take ? s_axi.araddr[ADDR_WIDTH-1:3] : (r_idx + IDX_ONE);

  // Read engine. The RAM read register is the RDATA holding register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_take) begin
            r_idx    <= s_axi.araddr[ADDR_WIDTH-1:3];
            r_len    <= s_axi.arlen;
            r_cnt    <= '0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= R_DATA;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_valid && s_axi.rready) begin
            if (r_cnt == r_len) begin
              r_valid <= 1'b0;
              r_state <= R_IDLE;
            end else begin
              r_idx <= r_idx + IDX_ONE;
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  aq_axi_sdma64_ram #(.IDX_W(IDX_W)) u_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .waddr (w_idx),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = b_valid;
  assign s_axi.bresp   = b_resp;
  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = r_valid;
  // The RAM output is not reset, so RDATA is forced to zero outside a valid beat.
  assign s_axi.rdata   = r_valid ? ram_q : '0;
  assign s_axi.rlast   = r_valid && (r_cnt == r_len);
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.w_state = w_state;
  assign s_axi.r_state = r_state;

endmodule

// File: tb/tb_aq_axi_sdma64_slave_mem.sv
// Directed bench for aq_axi_sdma64_slave_mem: bursts, strobes, wrap, WLAST errors, reset.
module tb_aq_axi_sdma64_slave_mem;
  import aq_axi_sdma64_pkg::*;

  logic clk;
  logic arst;
  int   n_checks;
  int   n_fail;
  logic [63:0] wbuf [256];
  logic [63:0] exp_q [$];

  aq_axi_sdma64_slave_mem_if s_axi ();

  aq_axi_sdma64_slave_mem #(.ADDR_WIDTH(16)) dut (
    .ACLK   (clk),
    .ARESET (arst),
    .s_axi  (s_axi)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [7:0] strb, input int n_beats, input int wlast_at,
                             input logic [1:0] exp_resp, input string name);
    int n;
    s_axi.awaddr = addr; s_axi.awlen = len; s_axi.awvalid = 1'b1;
    n = 0;
    while (s_axi.awready !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (n >= 50) begin $display("FAIL %s aw_timeout awready=%b required=1", name, s_axi.awready); n_fail++; end
    tick();
    s_axi.awvalid = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      s_axi.wdata = wbuf[i]; s_axi.wstrb = strb; s_axi.wlast = (i == wlast_at); s_axi.wvalid = 1'b1;
      n_checks++;
      if (s_axi.wready !== 1'b1) begin
        $display("FAIL %s wready beat %0d got=%b required=1", name, i, s_axi.wready); n_fail++;
      end
      tick();
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    n_checks++;
    if (s_axi.wready !== 1'b0) begin $display("FAIL %s wready_after_end got=%b required=0", name, s_axi.wready); n_fail++; end
    s_axi.bready = 1'b1;
    n = 0;
    while (s_axi.bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (s_axi.bvalid !== 1'b1) begin $display("FAIL %s b_timeout bvalid=%b required=1", name, s_axi.bvalid); n_fail++; end
    n_checks++;
    if (s_axi.bresp !== exp_resp) begin $display("FAIL %s bresp got=%b required=%b", name, s_axi.bresp, exp_resp); n_fail++; end
    tick();
    s_axi.bready = 1'b0;
    n_checks++;
    if (s_axi.bvalid !== 1'b0) begin $display("FAIL %s bvalid_after_b got=%b required=0", name, s_axi.bvalid); n_fail++; end
    n_checks++;
    if (s_axi.awready !== 1'b0) begin $display("FAIL %s awready_gap got=%b required=0", name, s_axi.awready); n_fail++; end
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                            input bit toggle, input string name);
    int n;
    int i;
    int cyc;
    s_axi.araddr = addr; s_axi.arlen = len; s_axi.arvalid = 1'b1;
    n = 0;
    while (s_axi.arready !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (n >= 50) begin $display("FAIL %s ar_timeout arready=%b required=1", name, s_axi.arready); n_fail++; end
    tick();
    s_axi.arvalid = 1'b0;
    n_checks++;
    if (s_axi.rvalid !== 1'b1) begin $display("FAIL %s rvalid_latency got=%b required=1", name, s_axi.rvalid); n_fail++; end
    i = 0; cyc = 0;
    while (i <= int'(len) && cyc < 2000) begin
      s_axi.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      n_checks++;
      if (s_axi.rvalid !== 1'b1) begin
        $display("FAIL %s rvalid beat %0d got=%b required=1", name, i, s_axi.rvalid); n_fail++;
        break;
      end
      n_checks++;
      if (s_axi.rdata !== exp_q[i]) begin
        $display("FAIL %s rdata beat %0d got=%h required=%h", name, i, s_axi.rdata, exp_q[i]); n_fail++;
      end
      n_checks++;
      if (s_axi.rlast !== (i == int'(len))) begin
        $display("FAIL %s rlast beat %0d got=%b required=%b", name, i, s_axi.rlast, (i == int'(len))); n_fail++;
      end
      if (s_axi.rready) i++;
      tick();
      cyc++;
    end
    s_axi.rready = 1'b0;
    n_checks++;
    if (i <= int'(len)) begin $display("FAIL %s beats_done got=%0d required=%0d", name, i, int'(len) + 1); n_fail++; end
    n_checks++;
    if (s_axi.rvalid !== 1'b0) begin $display("FAIL %s rvalid_after_last got=%b required=0", name, s_axi.rvalid); n_fail++; end
    exp_q.delete();
  endtask

  task automatic test_reset;
    arst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid, s_axi.rlast} !== 6'b0) begin
      $display("FAIL reset_ctrl got=%b required=000000",
               {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid, s_axi.rlast});
      n_fail++;
    end
    n_checks++;
    if ({s_axi.bresp, s_axi.rresp} !== 4'b0) begin $display("FAIL reset_resp got=%b required=0000", {s_axi.bresp, s_axi.rresp}); n_fail++; end
    n_checks++;
    if (s_axi.rdata !== 64'h0) begin $display("FAIL reset_rdata got=%h required=0", s_axi.rdata); n_fail++; end
    n_checks++;
    if (s_axi.w_state !== W_IDLE || s_axi.r_state !== R_IDLE) begin
      $display("FAIL reset_state got=%0d/%0d required=0/0", s_axi.w_state, s_axi.r_state); n_fail++;
    end
    arst = 1'b0;
    tick();
    n_checks++;
    if (s_axi.awready !== 1'b1 || s_axi.arready !== 1'b1) begin
      $display("FAIL reset_release aw/ar ready got=%b%b required=11", s_axi.awready, s_axi.arready); n_fail++;
    end
  endtask

  task automatic test_basic_burst;
    wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
    wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
    write_burst(32'h100, 8'd3, 8'hFF, 4, 3, RESP_OKAY, "basic_wr");
    exp_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    read_burst(32'h100, 8'd3, 1'b0, "basic_rd");
  endtask

  task automatic test_strobes;
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(32'h0, 8'd0, 8'hFF, 1, 0, RESP_OKAY, "strb_full");
    wbuf[0] = 64'h0;
    write_burst(32'h0, 8'd0, 8'h0F, 1, 0, RESP_OKAY, "strb_low");
    exp_q = '{64'hFFFF_FFFF_0000_0000};
    read_burst(32'h0, 8'd0, 1'b0, "strb_rd");
    wbuf[0] = 64'h1234_5678_9ABC_DEF0;
    write_burst(32'h0, 8'd0, 8'h00, 1, 0, RESP_OKAY, "strb_none");
    exp_q = '{64'hFFFF_FFFF_0000_0000};
    read_burst(32'h0, 8'd0, 1'b0, "strb_none_rd");
  endtask

  task automatic test_full_burst;
    for (int i = 0; i < 256; i++) wbuf[i] = 64'h0800_0000_0000_0000 + 64'(i);
    write_burst(32'h800, 8'd255, 8'hFF, 256, 255, RESP_OKAY, "full_wr");
    for (int i = 0; i < 256; i++) exp_q.push_back(64'h0800_0000_0000_0000 + 64'(i));
    read_burst(32'h800, 8'd255, 1'b1, "full_rd_toggle");
  endtask

  task automatic test_wrap;
    wbuf[0] = 64'hAAAA_0000_0000_FFF8; wbuf[1] = 64'hBBBB_0000_0000_0000;
    write_burst(32'hFFF8, 8'd1, 8'hFF, 2, 1, RESP_OKAY, "wrap_wr");
    exp_q = '{64'hBBBB_0000_0000_0000};
    read_burst(32'h0, 8'd0, 1'b0, "wrap_rd_word0");
    exp_q = '{64'hAAAA_0000_0000_FFF8, 64'hBBBB_0000_0000_0000};
    read_burst(32'hFFF8, 8'd1, 1'b0, "wrap_rd_span");
    exp_q = '{64'hBBBB_0000_0000_0000};
    read_burst(32'h0001_0000, 8'd0, 1'b0, "alias_rd");
  endtask

  task automatic test_wlast_errors;
    wbuf[0] = 64'hE0E0_E0E0_0000_0000; wbuf[1] = 64'hE1E1_E1E1_0000_0001;
    write_burst(32'h200, 8'd3, 8'hFF, 2, 1, RESP_SLVERR, "early_wlast");
    wbuf[0] = 64'h5555_5555_5555_5555;
    write_burst(32'h300, 8'd0, 8'hFF, 1, 0, RESP_OKAY, "after_err");
    exp_q = '{64'hE0E0_E0E0_0000_0000, 64'hE1E1_E1E1_0000_0001};
    read_burst(32'h200, 8'd1, 1'b0, "early_rd");
    exp_q = '{64'h5555_5555_5555_5555};
    read_burst(32'h300, 8'd0, 1'b0, "after_err_rd");
    wbuf[0] = 64'h7070_0000_0000_0000; wbuf[1] = 64'h7171_0000_0000_0000;
    write_burst(32'h400, 8'd1, 8'hFF, 2, -1, RESP_SLVERR, "missing_wlast");
  endtask

  task automatic test_reset_mid_read;
    int n;
    s_axi.araddr = 32'h100; s_axi.arlen = 8'd3; s_axi.arvalid = 1'b1;
    n = 0;
    while (s_axi.arready !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (n >= 50) begin $display("FAIL rst_rd ar_timeout arready=%b required=1", s_axi.arready); n_fail++; end
    tick();
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (s_axi.rdata !== 64'h3333_3333_3333_3333) begin
      $display("FAIL rst_rd beat3 got=%h required=3333333333333333", s_axi.rdata); n_fail++;
    end
    arst = 1'b1;
    #1;
    n_checks++;
    if (s_axi.rvalid !== 1'b0 || s_axi.rlast !== 1'b0) begin
      $display("FAIL rst_rd rvalid/rlast got=%b%b required=00", s_axi.rvalid, s_axi.rlast); n_fail++;
    end
    s_axi.rready = 1'b0;
    tick();
    n_checks++;
    if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b0) begin
      $display("FAIL rst_rd held rvalid/arready got=%b%b required=00", s_axi.rvalid, s_axi.arready); n_fail++;
    end
    arst = 1'b0;
    tick();
    n_checks++;
    if (s_axi.arready !== 1'b1 || s_axi.rvalid !== 1'b0) begin
      $display("FAIL rst_rd release arready/rvalid got=%b%b required=10", s_axi.arready, s_axi.rvalid); n_fail++;
    end
    exp_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    read_burst(32'h100, 8'd3, 1'b0, "rst_intact_rd");
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    arst = 1'b1;
    s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    test_reset();
    test_basic_burst();
    test_strobes();
    test_full_burst();
    test_wrap();
    test_wlast_errors();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
